// File: rtl/task_dispatcher_pkg.sv
// Shared definitions for the task dispatcher and the node control block address map.
// Holds the bus widths, the node count, the control-register address bits, the AXI
// response code and the dispatcher state encoding.
package task_dispatcher_pkg;

  localparam int unsigned AXI_ADDR_WIDTH             = 32;
  localparam int unsigned AXI_DATA_WIDTH             = 32;
  localparam int unsigned NUM_NODES_PROCESSING       = 32;
  localparam int unsigned NUM_NODES_PROCESSING_WIDTH = 5;

  // Control block address map: one select bit per register, node id in the low bits.
  localparam int unsigned ADDR_PROG_BIT = 7;
  localparam int unsigned ADDR_BUSY_BIT = 8;
  localparam int unsigned ADDR_NODE_LSB = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StPollAr,
    StPollR,
    StPick,
    StWait,
    StWr,
    StBresp
  } state_e;

endpackage

// File: rtl/if_axi_light.sv
// AXI-lite bundle between the dispatcher (master) and the node control block (slave).
// Carries the five AXI-lite channels: AW, W, B, AR and R.
interface if_axi_light;
  import task_dispatcher_pkg::*;

  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/dispatch_fifo.sv
// Synchronous task FIFO with registered count, empty and ready (not-full) flags.
// Ports: clk, res_n (sync active-low), push/push_data, pop, head (oldest entry),
//        count, empty, ready (0 while in reset and while full).
module dispatch_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             empty_q, ready_q;
  logic             do_push, do_pop;

  // ready_q is the registered not-full flag, so a push into a full FIFO is refused even
  // when a pop happens in the same cycle.
  assign do_push = push && ready_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      ready_q <= (count_d != FullCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = empty_q;
  assign ready = ready_q;

endmodule

// File: rtl/task_dispatcher.sv
// AXI-lite master that queues program offsets and hands each one to the lowest-indexed
// idle, enabled processing node by writing the node's program register.
// Ports: clk, res_n (sync active-low), m_axi (AXI-lite master), task_valid/task_offset/
//        task_ready (task push), node_enable (usable nodes), fifo_count (queued tasks),
//        dispatched (successful dispatches, wraps), last_node, err (sticky: [0] zero
//        offset, [1] non-OKAY response).
module task_dispatcher
  import task_dispatcher_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] CTRL_BASE  = 32'h8000_0000,
  parameter int unsigned POLL_GAP   = 16,
  parameter int unsigned PROG_BIT   = ADDR_PROG_BIT,
  parameter int unsigned BUSY_BIT   = ADDR_BUSY_BIT,
  parameter int unsigned NODE_LSB   = ADDR_NODE_LSB
) (
  input  logic                                  clk,
  input  logic                                  res_n,
  if_axi_light.master                           m_axi,
  input  logic                                  task_valid,
  input  logic [AXI_DATA_WIDTH-1:0]             task_offset,
  output logic                                  task_ready,
  input  logic [NUM_NODES_PROCESSING-1:0]       node_enable,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  output logic [31:0]                           dispatched,
  output logic [NUM_NODES_PROCESSING_WIDTH-1:0] last_node,
  output logic [1:0]                            err
);

  localparam logic [15:0] PollGap = 16'(POLL_GAP);

  state_e                                state_q;
  logic [15:0]                           poll_cnt_q;
  logic [NUM_NODES_PROCESSING-1:0]       free_q;
  logic [NUM_NODES_PROCESSING_WIDTH-1:0] node_q, last_node_q;
  logic [AXI_DATA_WIDTH-1:0]             wdata_q, fifo_head;
  logic [AXI_ADDR_WIDTH-1:0]             awaddr_q;
  logic                                  arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic [31:0]                           dispatched_q;
  logic [1:0]                            err_q;
  logic                                  fifo_empty, fifo_push, fifo_pop, zero_push;

  function automatic logic [NUM_NODES_PROCESSING_WIDTH-1:0] pick_lowest(
    input logic [NUM_NODES_PROCESSING-1:0] v
  );
    pick_lowest = '0;
    for (int i = NUM_NODES_PROCESSING - 1; i >= 0; i--) begin
      if (v[i]) pick_lowest = NUM_NODES_PROCESSING_WIDTH'(i);
    end
  endfunction

  // Zero offsets are consumed from the producer but never queued.
  assign zero_push = task_valid && task_ready && (task_offset == '0);
  assign fifo_push = task_valid && task_ready && (task_offset != '0);
  assign fifo_pop  = (state_q == StPick) && (free_q != '0);

  dispatch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXI_DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .res_n     (res_n),
    .push      (fifo_push),
    .push_data (task_offset),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .ready     (task_ready)
  );

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q      <= StIdle;
      poll_cnt_q   <= '0;
      free_q       <= '0;
      node_q       <= '0;
      last_node_q  <= '0;
      wdata_q      <= '0;
      awaddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      dispatched_q <= '0;
      err_q        <= '0;
    end else begin
      if (zero_push) err_q[0] <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            arvalid_q <= 1'b1;
            state_q   <= StPollAr;
          end
        end
        StPollAr: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StPollR;
          end
        end
        StPollR: begin
          if (m_axi.rvalid) begin
            rready_q <= 1'b0;
            if (m_axi.rresp == RESP_OKAY) begin
              free_q <= ~m_axi.rdata[NUM_NODES_PROCESSING-1:0] & node_enable;
            end else begin
              free_q   <= '0;
              err_q[1] <= 1'b1;
            end
            state_q <= StPick;
          end
        end
        StPick: begin
          if (free_q == '0) begin
            if (POLL_GAP == 0) begin
              arvalid_q <= 1'b1;
              state_q   <= StPollAr;
            end else begin
              poll_cnt_q <= PollGap;
              state_q    <= StWait;
            end
          end else begin
            node_q    <= pick_lowest(free_q);
            awaddr_q  <= CTRL_BASE | (32'(1) << PROG_BIT)
                       | (32'(pick_lowest(free_q)) << NODE_LSB);
            wdata_q   <= fifo_head;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= StWr;
          end
        end
        StWait: begin
          // Exactly POLL_GAP cycles are spent here before the next busy read.
          poll_cnt_q <= poll_cnt_q - 16'd1;
          if (poll_cnt_q <= 16'd1) begin
            arvalid_q <= 1'b1;
            state_q   <= StPollAr;
          end
        end
        StWr: begin
          if (m_axi.awready) awvalid_q <= 1'b0;
          if (m_axi.wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
            bready_q <= 1'b1;
            state_q  <= StBresp;
          end
        end
        StBresp: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            if (m_axi.bresp == RESP_OKAY) begin
              dispatched_q <= dispatched_q + 32'd1;
              last_node_q  <= node_q;
            end else begin
              err_q[1] <= 1'b1;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axi.araddr  = CTRL_BASE | (32'(1) << BUSY_BIT);
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

  assign dispatched = dispatched_q;
  assign last_node  = last_node_q;
  assign err        = err_q;

endmodule
